// File: rtl/mem_arbiter.sv
// Two-requestor (IFU/LSU) round-robin arbiter in front of a single-port word memory, optional RMW for sub-word stores.
// Latency: grant at c0, strobe c1, ready c2, rvalid c3; RMW write completes at c5. Zero-strobe write completes at c1.
// Backpressure: gnt only in IDLE, requestors hold req until gnt; one transaction outstanding. Optional feature macro: MEM_ARB_RMW_EN.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter bit RESET_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [31:0]       ifu_rdata,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    input  logic [3:0]        lsu_wstrb,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [31:0]       lsu_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

`ifdef MEM_ARB_RMW_EN
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RMW_WR} state_t;
`else
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
`endif

    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    state_t state;
    logic   owner;   // 0 = IFU owns the tie, 1 = LSU
    logic   src;     // source of the in-flight transaction, 1 = LSU
    logic   we_q;
    logic   idle;

`ifdef MEM_ARB_RMW_EN
    logic        rmw_rd;   // in-flight access is the read half of an RMW
    logic [3:0]  wstrb_q;
    logic [31:0] merged;

    // Byte-wise merge: store data on enabled lanes, memory data elsewhere.
    // mem_wdata carries the latched store data during the read phase.
    always_comb begin
        merged = mem_rdata;
        for (int i = 0; i < 4; i++) begin
            if (wstrb_q[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
        end
    end
`endif

    // Grants are combinational, only in IDLE; gated by reset so every output reads 0 in reset.
    assign idle    = (state == IDLE) && rst_n;
    assign ifu_gnt = idle && ifu_req && (!lsu_req || !owner);
    assign lsu_gnt = idle && lsu_req && (!ifu_req ||  owner);

    // Transaction FSM with registered strobes, completions and read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= RESET_PRIO;
            src        <= 1'b0;
            we_q       <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
`ifdef MEM_ARB_RMW_EN
            rmw_rd     <= 1'b0;
            wstrb_q    <= '0;
`endif
        end else begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            ifu_rvalid <= 1'b0;
            lsu_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ifu_gnt) begin
                        owner    <= 1'b1;
                        src      <= 1'b0;
                        we_q     <= 1'b0;
                        mem_addr <= ifu_addr & WORD_MASK;
                        mem_read <= 1'b1;
                        state    <= ISSUE;
                    end else if (lsu_gnt) begin
                        owner    <= 1'b0;
                        src      <= 1'b1;
                        we_q     <= lsu_we;
                        mem_addr <= lsu_addr & WORD_MASK;
                        if (lsu_we && lsu_wstrb == 4'h0) begin
                            // Nothing to store: complete without touching memory.
                            lsu_rvalid <= 1'b1;
                            lsu_rdata  <= '0;
                        end else if (!lsu_we) begin
                            mem_read <= 1'b1;
                            state    <= ISSUE;
`ifdef MEM_ARB_RMW_EN
                        end else if (lsu_wstrb != 4'hF) begin
                            mem_read  <= 1'b1;
                            mem_wdata <= lsu_wdata;
                            wstrb_q   <= lsu_wstrb;
                            rmw_rd    <= 1'b1;
                            state     <= ISSUE;
`endif
                        end else begin
                            mem_write <= 1'b1;
                            mem_wdata <= lsu_wdata;
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mem_ready) begin
`ifdef MEM_ARB_RMW_EN
                        if (rmw_rd) begin
                            rmw_rd    <= 1'b0;
                            mem_wdata <= merged;
                            mem_write <= 1'b1;
                            state     <= RMW_WR;
                        end else
`endif
                        begin
                            state <= IDLE;
                            if (src) begin
                                lsu_rvalid <= 1'b1;
                                lsu_rdata  <= we_q ? 32'h0 : mem_rdata;
                            end else begin
                                ifu_rvalid <= 1'b1;
                                ifu_rdata  <= mem_rdata;
                            end
                        end
                    end
                end
`ifdef MEM_ARB_RMW_EN
                RMW_WR: state <= WAIT;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-ready word memory model.
// Checks reset state, arbitration, read/write latency, partial and zero-strobe writes, reset mid-transaction.
// All comparisons go through check(); summary line at end.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ifu_req = 1'b0;
    logic [31:0] ifu_addr = '0;
    logic        ifu_gnt, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [3:0]  lsu_wstrb = '0;
    logic        lsu_gnt, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    logic [31:0] mem [0:255];
    int n_chk = 0, n_fail = 0;
    int n_rd = 0, n_wr = 0, n_excl = 0;
    int ready_dly = 0;

    mem_arbiter #(.ADDR_W(32), .RESET_PRIO(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Strobe statistics, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_read) n_rd++;
        if (mem_write) n_wr++;
        if (mem_read && mem_write) n_excl++;
    end

    // Memory model: ready (and read data) during the cycle after the strobe, plus ready_dly cycles.
    initial begin
        logic [7:0] idx;
        logic       rd;
        forever begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                idx = mem_addr[9:2];
                rd  = mem_read;
                if (mem_write) mem[idx] = mem_wdata;
                @(posedge clk);
                repeat (ready_dly) @(posedge clk);
                #1;
                mem_ready = 1'b1;
                mem_rdata = rd ? mem[idx] : 32'h0;
                @(posedge clk);
                #1;
                mem_ready = 1'b0;
            end
        end
    end

    task automatic ifu_op(input logic [31:0] addr, input logic [31:0] exp_data, input string tag);
        int k;
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_addr = addr;
        @(negedge clk);
        check({tag, "_gnt"}, {31'h0, ifu_gnt}, 32'h1);
        @(posedge clk); #1;
        ifu_req = 1'b0;
        @(negedge clk);
        check({tag, "_rd_c1"}, {30'h0, mem_read, mem_write}, 32'h2);
        check({tag, "_addr_c1"}, mem_addr, addr & ~32'h3);
        for (k = 2; k <= 12; k++) begin
            @(negedge clk);
            if (ifu_rvalid) break;
        end
        check({tag, "_lat"}, k, 3);
        check({tag, "_data"}, ifu_rdata, exp_data);
    endtask

    task automatic lsu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input int exp_lat, input logic [31:0] exp_data,
                          input string tag);
        int k;
        @(posedge clk); #1;
        lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = wdata; lsu_wstrb = wstrb;
        @(negedge clk);
        check({tag, "_gnt"}, {31'h0, lsu_gnt}, 32'h1);
        @(posedge clk); #1;
        lsu_req = 1'b0;
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lsu_rvalid) break;
        end
        check({tag, "_lat"}, k, exp_lat);
        check({tag, "_data"}, lsu_rdata, exp_data);
    endtask

    task automatic arb_round(input logic exp_ifu, input string tag);
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_addr = 32'h100;
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 32'h100;
        @(negedge clk);
        check(tag, {30'h0, ifu_gnt, lsu_gnt}, exp_ifu ? 32'h2 : 32'h1);
        @(posedge clk); #1;
        ifu_req = 1'b0; lsu_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int rd0, wr0, cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        mem[8'hC0] = 32'hAABBCCDD;

        // Reset state
        #12;
        check("rst_ctl", {26'h0, ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_read, mem_write}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_rdata", ifu_rdata | lsu_rdata | mem_wdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Arbitration: tie goes IFU then LSU; LSU alone is granted at once
        arb_round(1'b1, "arb_first_ifu");
        arb_round(1'b0, "arb_second_lsu");
        lsu_op(1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, "lsu_alone1");
        lsu_op(1'b0, 32'h100, 32'h0, 4'h0, 3, 32'hDEADBEEF, "lsu_alone2");

        // IFU read with unaligned byte address
        ifu_op(32'h102, 32'hDEADBEEF, "ifu_rd");

        // Full write then read back
        lsu_op(1'b1, 32'h200, 32'h11223344, 4'hF, 3, 32'h0, "full_wr");
        check("full_wr_mem", mem[8'h80], 32'h11223344);
        lsu_op(1'b0, 32'h200, 32'h0, 4'h0, 3, 32'h11223344, "full_rd");

        // Partial write
        rd0 = n_rd; wr0 = n_wr;
`ifdef MEM_ARB_RMW_EN
        lsu_op(1'b1, 32'h300, 32'h0000EE00, 4'b0010, 5, 32'h0, "part_wr");
        check("part_mem", mem[8'hC0], 32'hAABBEEDD);
        check("part_strobes", ((n_rd - rd0) << 8) | (n_wr - wr0), 32'h101);
`else
        lsu_op(1'b1, 32'h300, 32'h0000EE00, 4'b0010, 3, 32'h0, "part_wr");
        check("part_mem", mem[8'hC0], 32'h0000EE00);
        check("part_strobes", ((n_rd - rd0) << 8) | (n_wr - wr0), 32'h001);
`endif

        // Zero strobe: no memory access, completion one cycle after grant
        rd0 = n_rd; wr0 = n_wr;
        lsu_op(1'b1, 32'h300, 32'h12345678, 4'h0, 1, 32'h0, "zero_wr");
        repeat (3) @(negedge clk);
        check("zero_strobes", (n_rd - rd0) + (n_wr - wr0), 32'h0);

        // Reset while in WAIT; ready arrives after release and must be dropped
        ready_dly = 2;
        @(posedge clk); #1;
        ifu_req = 1'b1; ifu_addr = 32'h100;
        @(negedge clk);
        check("rstw_gnt", {31'h0, ifu_gnt}, 32'h1);
        @(posedge clk); #1;
        ifu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rstw_ctl", {26'h0, ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid, mem_read, mem_write}, 32'h0);
        check("rstw_addr", mem_addr, 32'h0);
        check("rstw_rdata", ifu_rdata, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifu_rvalid || lsu_rvalid) cnt++;
        end
        check("rstw_no_rvalid", cnt, 0);
        ready_dly = 0;
        ifu_op(32'h200, 32'h11223344, "post_rst_rd");

        check("strobe_excl", n_excl, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
